// File: rtl/io_handshake_ctrl.sv
// Board-side handshake partner for the picoMIPS core: synchronises and debounces the
// push-button, snapshots the switches per press, and holds the last nonzero CPU output on LEDs.
module io_handshake_ctrl #(
  parameter int n   = 8,
  parameter int DBW = 20,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_n,
  input  logic [n-1:0]  sw_raw,
  input  logic [n-1:0]  outport,
  output logic [n-1:0]  SW,
  output logic          branch_status,
  output logic [n-1:0]  led,
  output logic          led_update,
  output logic [CW-1:0] press_count
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  localparam logic [DBW-1:0] DEB_MAX  = {DBW{1'b1}};
  localparam logic [DBW-1:0] DEB_ZERO = {DBW{1'b0}};
  localparam logic [DBW-1:0] DEB_ONE  = {{(DBW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [n-1:0]   DATA_ZERO = {n{1'b0}};

  // Synchroniser stages; the key side idles high (released).
  logic         key_meta_r;
  logic         key_sync_r;
  logic [n-1:0] sw_meta_r;
  logic [n-1:0] sw_sync_r;

  // Debounce state; deb_level_r follows key polarity (1 = released).
  logic           deb_level_r;
  logic           deb_level_s;
  logic [DBW-1:0] deb_cnt_r;
  logic [DBW-1:0] deb_cnt_s;

  // Press FSM and its registered outputs.
  state_t        state_r;
  state_t        state_s;
  logic [n-1:0]  sw_snap_r;
  logic [n-1:0]  sw_snap_s;
  logic [CW-1:0] press_cnt_r;
  logic [CW-1:0] press_cnt_s;
  logic          branch_r;
  logic          branch_s;

  // LED capture.
  logic [n-1:0] led_r;
  logic [n-1:0] led_s;
  logic         led_upd_r;
  logic         led_upd_s;

  // Two-flop synchronisers on the asynchronous board pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      sw_meta_r  <= DATA_ZERO;
      sw_sync_r  <= DATA_ZERO;
    end else begin
      key_meta_r <= key_n;
      key_sync_r <= key_meta_r;
      sw_meta_r  <= sw_raw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Debounce next-state: any return to the accepted level restarts the count.
  always_comb begin
    deb_level_s = deb_level_r;
    deb_cnt_s   = deb_cnt_r;
    if (key_sync_r == deb_level_r) begin
      deb_cnt_s = DEB_ZERO;
    end else if (deb_cnt_r == DEB_MAX) begin
      deb_level_s = ~deb_level_r;
      deb_cnt_s   = DEB_ZERO;
    end else begin
      deb_cnt_s = deb_cnt_r + DEB_ONE;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_level_r <= 1'b1;
      deb_cnt_r   <= DEB_ZERO;
    end else begin
      deb_level_r <= deb_level_s;
      deb_cnt_r   <= deb_cnt_s;
    end
  end

  // FSM next-state and output decode; SW and the count move only on IDLE->PRESSED.
  always_comb begin
    state_s     = state_r;
    sw_snap_s   = sw_snap_r;
    press_cnt_s = press_cnt_r;
    case (state_r)
      IDLE: begin
        if (!deb_level_r) begin
          state_s     = PRESSED;
          sw_snap_s   = sw_sync_r;
          press_cnt_s = press_cnt_r + CNT_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      PRESSED: begin
        if (deb_level_r) begin
          state_s = IDLE;
        end else begin
          state_s = PRESSED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    branch_s = (state_s == PRESSED);
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      sw_snap_r   <= DATA_ZERO;
      press_cnt_r <= {CW{1'b0}};
      branch_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      sw_snap_r   <= sw_snap_s;
      press_cnt_r <= press_cnt_s;
      branch_r    <= branch_s;
    end
  end

  // Capture rule: zero means "no output", repeats of the held value are not updates.
  always_comb begin
    led_s     = led_r;
    led_upd_s = 1'b0;
    if ((outport != DATA_ZERO) && (outport != led_r)) begin
      led_s     = outport;
      led_upd_s = 1'b1;
    end else begin
      led_s     = led_r;
      led_upd_s = 1'b0;
    end
  end

  // LED register and update strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_r     <= DATA_ZERO;
      led_upd_r <= 1'b0;
    end else begin
      led_r     <= led_s;
      led_upd_r <= led_upd_s;
    end
  end

  assign SW            = sw_snap_r;
  assign branch_status = branch_r;
  assign press_count   = press_cnt_r;
  assign led           = led_r;
  assign led_update    = led_upd_r;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Scoreboard bench for io_handshake_ctrl with DBW=4: stimulus queues expected press and LED
// events, a negedge monitor pops and checks them when the DUT raises branch_status or led_update.
module tb_io_handshake_ctrl;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic [7:0] sw_raw;
  logic [7:0] outport;
  logic [7:0] SW;
  logic       branch_status;
  logic [7:0] led;
  logic       led_update;
  logic [7:0] press_count;

  typedef struct {
    logic [7:0]  sw;
    logic [7:0]  cnt;
    int unsigned cyc;
  } press_exp_t;

  press_exp_t  press_q[$];
  logic [7:0]  led_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          led_pulses = 0;
  logic        bs_prev = 1'b0;
  logic [7:0]  sw_cur;
  logic [7:0]  cnt_exp;

  io_handshake_ctrl #(.n(8), .DBW(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_raw(sw_raw), .outport(outport),
    .SW(SW), .branch_status(branch_status), .led(led), .led_update(led_update),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // A press accepted from a key edge driven now shows up 19 edges later.
  task automatic press_expect(input logic [7:0] sw_e, input logic [7:0] cnt_e);
    press_exp_t e;
    e.sw  = sw_e;
    e.cnt = cnt_e;
    e.cyc = cyc + 19;
    press_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_SW"}, {24'h0, SW}, 32'h0);
    chk({tag, "_branch"}, {31'h0, branch_status}, 32'h0);
    chk({tag, "_count"}, {24'h0, press_count}, 32'h0);
    chk({tag, "_led"}, {24'h0, led}, 32'h0);
    chk({tag, "_led_update"}, {31'h0, led_update}, 32'h0);
  endtask

  // Monitor: pop expectations whenever the DUT presents a press or LED update.
  always @(negedge clk) begin
    press_exp_t e;
    logic [7:0] l;
    if (reset && branch_status && !bs_prev) begin
      if (press_q.size() == 0) begin
        chk("unexpected_press", {24'h0, press_count}, 32'hFFFF_FFFF);
      end else begin
        e = press_q.pop_front();
        chk("press_SW", {24'h0, SW}, {24'h0, e.sw});
        chk("press_count", {24'h0, press_count}, {24'h0, e.cnt});
        chk("press_cycle", cyc, e.cyc);
      end
    end
    if (reset && led_update) begin
      led_pulses++;
      if (led_q.size() == 0) begin
        chk("unexpected_led_update", {24'h0, led}, 32'hFFFF_FFFF);
      end else begin
        l = led_q.pop_front();
        chk("led_value", {24'h0, led}, {24'h0, l});
      end
    end
    bs_prev = branch_status;
  end

  initial begin
    int pulses_base;
    reset   = 1'b0;
    key_n   = 1'b1;
    sw_raw  = 8'hA5;
    outport = 8'h00;
    step(1);
    #1;
    chk_all_zero("in_reset");
    step(2);
    reset = 1'b1;
    step(50);
    chk_all_zero("idle_after_reset");

    // First press latches 3C.
    sw_raw = 8'h3C;
    key_n  = 1'b0;
    press_expect(8'h3C, 8'd1);
    step(25);
    chk("held_branch", {31'h0, branch_status}, 32'h1);
    sw_raw = 8'hFF;
    step(8);
    chk("SW_held_while_pressed", {24'h0, SW}, 32'h3C);
    chk("count_held_while_pressed", {24'h0, press_count}, 32'h1);

    // Release, then a second press latches FF.
    key_n = 1'b1;
    step(20);
    chk("branch_released", {31'h0, branch_status}, 32'h0);
    key_n = 1'b0;
    press_expect(8'hFF, 8'd2);
    step(25);
    key_n = 1'b1;
    step(22);

    // Glitches shorter than the debounce window are rejected.
    repeat (5) begin
      key_n = 1'b0;
      step(10);
      key_n = 1'b1;
      step(3);
    end
    step(20);
    chk("glitch_branch", {31'h0, branch_status}, 32'h0);
    chk("glitch_count", {24'h0, press_count}, 32'h2);

    // Outport capture: 0, 12, 12, 0, 34.
    pulses_base = led_pulses;
    outport = 8'h00;
    step(1);
    outport = 8'h12;
    led_q.push_back(8'h12);
    step(1);
    outport = 8'h12;
    step(1);
    outport = 8'h00;
    step(1);
    chk("led_holds_on_zero", {24'h0, led}, 32'h12);
    outport = 8'h34;
    led_q.push_back(8'h34);
    step(1);
    outport = 8'h00;
    step(3);
    chk("led_final", {24'h0, led}, 32'h34);
    chk("led_pulse_count", led_pulses - pulses_base, 32'd2);

    // Reset mid-debounce: the held key needs a fresh full count.
    sw_raw = 8'h96;
    key_n  = 1'b0;
    step(8);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_mid_count");
    step(1);
    reset = 1'b1;
    press_expect(8'h96, 8'd1);
    step(25);

    // Reset while pressed.
    chk("pressed_before_reset", {31'h0, branch_status}, 32'h1);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_pressed");
    step(1);
    reset = 1'b1;
    press_expect(8'h96, 8'd1);
    step(25);
    key_n = 1'b1;
    step(22);

    // Clean reset, then 256 presses wrap the count back to 0.
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(5);
    chk("count_cleared", {24'h0, press_count}, 32'h0);
    cnt_exp = 8'd0;
    for (int i = 0; i < 256; i++) begin
      sw_cur  = i[7:0] ^ 8'h5A;
      sw_raw  = sw_cur;
      step(5);
      cnt_exp = cnt_exp + 8'd1;
      key_n   = 1'b0;
      press_expect(sw_cur, cnt_exp);
      step(22);
      key_n = 1'b1;
      step(22);
    end
    step(5);
    chk("count_wrapped", {24'h0, press_count}, 32'h0);
    chk("press_queue_drained", press_q.size(), 32'd0);
    chk("led_queue_drained", led_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_handshake_ctrl.md
Name: io_handshake_ctrl

Overview:
- Board-side partner of the picoMIPS core. It produces the core's `SW` and `branch_status` inputs and consumes its `outport` output.
- Synchronises and debounces a push-button and synchronises the raw slide switches. On each debounced press it latches a stable `SW` snapshot and raises `branch_status` for the CPU to poll.
- Captures nonzero `outport` values into a held LED display register.
- Sits between the top-level board pins and the picoMIPS instance.

Parameters:
- n, 8, data width of switches, `SW` and `outport`.
- DBW, 20, debounce counter width. The button level must differ from the debounced level for 2^DBW consecutive cycles to be accepted.
- CW, 8, width of the press event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low master reset (low = reset).
- key_n  input  1  raw push-button, active-low, asynchronous to clk.
- sw_raw  input  n  raw slide switches, asynchronous to clk.
- outport  input  n  CPU output port; value 0 means "no output".
- SW  output  n  switch snapshot presented to the CPU.
- branch_status  output  1  high while a debounced press is held.
- led  output  n  last nonzero outport value captured.
- led_update  output  1  one-cycle pulse when led changes value.
- press_count  output  CW  number of accepted presses, wraps modulo 2^CW.

Behaviour:
- Reset (reset low, asynchronous), all state cleared:
  - sync flops: key side to 1 (released), sw side to 0;
  - debounced level to released; debounce counter to 0;
  - FSM to IDLE; outputs SW, led, led_update, press_count, branch_status all 0.
- Reset asserted mid-press or mid-count abandons all state immediately. After release, the bench must see a fresh full debounce before any press is accepted.
- Synchronisers: two flops each on key_n and on every sw_raw bit. No other logic reads the raw pins.
- Debounce, per cycle:
  - if synced key equals the debounced level, counter <= 0;
  - else, if counter == 2^DBW-1, the debounced level flips and counter <= 0;
  - else counter increments.
  - A glitch shorter than 2^DBW cycles never flips the level; any return to the debounced level restarts the count from 0.
- FSM, Moore, two states:
  - IDLE: branch_status=0. On debounced level = pressed, in the cycle after the flip: go to PRESSED, SW <= synced switches, press_count <= press_count+1 (wraps).
  - PRESSED: branch_status=1. SW is held constant regardless of sw_raw. On debounced level = released, return to IDLE.
  - The FSM moves at most one state per cycle. A press requires a prior release; holding the button yields exactly one event.
- Latency: a key_n edge stable from cycle t is reflected in the synced signal at t+2. The debounced flip occurs at t+2+2^DBW. branch_status and SW change one cycle after the flip.
- SW changes only on an IDLE->PRESSED transition. Changing switches while the button is held has no effect until the next press.
- Outport capture, every cycle:
  - if outport != 0 and outport != led: led <= outport and led_update <= 1;
  - otherwise led holds and led_update <= 0.
  - outport returning to 0 never clears led. A repeated identical nonzero value does not pulse led_update.
- Outport capture is independent of the FSM. A press and a capture in the same cycle are both performed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (DBW=4, n=8):
- Reset, then key_n=1, sw_raw=8'hA5 for 50 cycles -> SW=0, branch_status=0, press_count=0, led=0.
- sw_raw=8'h3C; key_n low for 30 cycles -> branch_status rises exactly 19 cycles after the key_n fall (2 sync + 16 debounce + 1 FSM). Then SW=8'h3C and press_count=1.
- While PRESSED, change sw_raw to 8'hFF -> SW stays 8'h3C. Release key_n for 20 cycles -> branch_status falls. The next press latches 8'hFF and press_count=2.
- key_n low-glitch pulses of 10 cycles separated by 3 cycles high, repeated 5 times -> no press accepted, branch_status stays 0, press_count unchanged.
- outport sequence 0, 8'h12, 8'h12, 0, 8'h34 -> led goes 0→12→34, with led_update pulsing exactly twice. led stays 12 during the zero cycle.
- Assert reset for 1 cycle midway through a debounce count and while PRESSED -> all outputs 0 immediately. A key still held low needs a full 16-cycle count after reset release before it is accepted as a new press. Also drive 256 presses -> press_count wraps to 0.
